hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 27 ++
 rtl/hazard_ctrl_fwd_mux.sv | 28 ++
 rtl/hazard_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared pipeline encodings for decode/execute hazard handling
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } hz_state_t;

   localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
      logic       is_load;
   } stage_t;

   function automatic logic is_load_code(input logic [1:0] resultsrc);
      return resultsrc == RESULTSRC_LOAD;
   endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_mux.sv
// rtl/hazard_ctrl_fwd_mux.sv - per-operand forward select, MEM result preferred over WB
module hazard_fwd_mux
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0] i_rs,
   input  logic       i_mem_wr,
   input  logic [4:0] i_mem_rd,
   input  logic       i_wb_wr,
   input  logic [4:0] i_wb_rd,
   output logic [1:0] o_sel
);

   logic w_mem_hit;
   logic w_wb_hit;

   // x0 is hardwired zero, so a writer to it never supplies a value
   assign w_mem_hit = i_mem_wr && (i_mem_rd != 5'd0) && (i_mem_rd == i_rs);
   assign w_wb_hit  = i_wb_wr  && (i_wb_rd  != 5'd0) && (i_wb_rd  == i_rs);

   always_comb begin
      o_sel = FWD_RF;
      if (w_mem_hit)
         o_sel = FWD_MEM;
      else if (w_wb_hit)
         o_sel = FWD_WB;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, branch flush and operand forwarding control
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  id_rd,
   input  logic        id_regwrite,
   input  logic [1:0]  id_resultsrc,
   input  logic        ex_pcsrc,
   output logic        stall_f,
   output logic        stall_d,
   output logic        flush_d,
   output logic        flush_e,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic [15:0] stall_cnt
);

   hz_state_t   r_state;
   stage_t      r_ex;
   stage_t      r_mem;
   stage_t      r_wb;
   logic [4:0]  r_ex_rs1;
   logic [4:0]  r_ex_rs2;
   logic [15:0] r_stall_cnt;

   logic        w_load_use;
   logic        w_stall;
   logic        w_flush;
   logic        w_ex_load;
   logic [15:0] w_cnt_next;
   logic [1:0]  w_fwd_a;
   logic [1:0]  w_fwd_b;
   logic        w_unused;

   assign w_load_use = r_ex.valid && r_ex.is_load && r_ex.regwrite && (r_ex.rd != 5'd0)
                       && id_valid && ((r_ex.rd == id_rs1) || (r_ex.rd == id_rs2));

   // A redirect discards the decode instruction, so it overrides any load-use stall
   assign w_flush    = !rst && ex_pcsrc;
   assign w_stall    = !rst && !ex_pcsrc && (r_state == ST_RUN) && w_load_use;
   assign w_ex_load  = id_valid && !w_stall && !w_flush;
   assign w_cnt_next = (w_stall && (r_stall_cnt != 16'hFFFF)) ? r_stall_cnt + 16'd1 : r_stall_cnt;
   assign w_unused   = r_wb.is_load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex        <= '0;
         r_mem       <= '0;
         r_wb        <= '0;
         r_ex_rs1    <= 5'd0;
         r_ex_rs2    <= 5'd0;
         r_stall_cnt <= 16'd0;
      end else begin
         r_wb        <= r_mem;
         r_mem       <= r_ex;
         r_stall_cnt <= w_cnt_next;
         if (w_ex_load) begin
            r_ex.valid    <= 1'b1;
            r_ex.rd       <= id_rd;
            r_ex.regwrite <= id_regwrite;
            r_ex.is_load  <= is_load_code(id_resultsrc);
            r_ex_rs1      <= id_rs1;
            r_ex_rs2      <= id_rs2;
         end else begin
            r_ex     <= '0;
            r_ex_rs1 <= 5'd0;
            r_ex_rs2 <= 5'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (ex_pcsrc)
                  r_state <= ST_FLUSH;
               else if (w_load_use)
                  r_state <= ST_STALL;
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   hazard_fwd_mux u_fwd_a (
      .i_rs     (r_ex_rs1),
      .i_mem_wr (r_mem.valid && r_mem.regwrite),
      .i_mem_rd (r_mem.rd),
      .i_wb_wr  (r_wb.valid && r_wb.regwrite),
      .i_wb_rd  (r_wb.rd),
      .o_sel    (w_fwd_a)
   );

   hazard_fwd_mux u_fwd_b (
      .i_rs     (r_ex_rs2),
      .i_mem_wr (r_mem.valid && r_mem.regwrite),
      .i_mem_rd (r_mem.rd),
      .i_wb_wr  (r_wb.valid && r_wb.regwrite),
      .i_wb_rd  (r_wb.rd),
      .o_sel    (w_fwd_b)
   );

   assign stall_f   = w_stall;
   assign stall_d   = w_stall;
   assign flush_d   = w_flush;
   assign flush_e   = w_flush || w_stall;
   assign fwd_a     = rst ? FWD_RF : w_fwd_a;
   assign fwd_b     = rst ? FWD_RF : w_fwd_b;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rd;
   logic        id_regwrite;
   logic [1:0]  id_resultsrc;
   logic        ex_pcsrc;
   logic        stall_f;
   logic        stall_d;
   logic        flush_d;
   logic        flush_e;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;
   logic [15:0] stall_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rd        (id_rd),
      .id_regwrite  (id_regwrite),
      .id_resultsrc (id_resultsrc),
      .ex_pcsrc     (ex_pcsrc),
      .stall_f      (stall_f),
      .stall_d      (stall_d),
      .flush_d      (flush_d),
      .flush_e      (flush_e),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .stall_cnt    (stall_cnt)
   );

   // ctl = {stall_f, stall_d, flush_d, flush_e}, fwd = {fwd_a, fwd_b}
   wire [3:0] ctl = {stall_f, stall_d, flush_d, flush_e};
   wire [3:0] fwd = {fwd_a, fwd_b};

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic rw, input logic [1:0] rsrc,
                      input logic pc);
      id_valid     = v;
      id_rs1       = rs1;
      id_rs2       = rs2;
      id_rd        = rd;
      id_regwrite  = rw;
      id_resultsrc = rsrc;
      ex_pcsrc     = pc;
      #1;
   endtask

   task automatic idle();
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      idle();
      repeat (3) tick();
   endtask

   initial begin
      rst = 1'b1;
      drv(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 2'b01, 1'b1);
      chk("rst_ctl", {12'd0, ctl}, 16'h0000);
      chk("rst_fwd", {12'd0, fwd}, 16'h0000);
      chk("rst_cnt", stall_cnt, 16'h0000);
      tick();
      tick();
      rst = 1'b0;
      idle();
      chk("idle_ctl", {12'd0, ctl}, 16'h0000);

      // lw x5 ; add x6,x5,x7
      drv(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0);
      chk("lu_pre", {12'd0, ctl}, 16'h0000);
      tick();
      drv(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 2'b00, 1'b0);
      chk("lu_stall", {12'd0, ctl}, 16'h000D);
      tick();
      drv(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 2'b00, 1'b0);
      chk("lu_one_cycle", {12'd0, ctl}, 16'h0000);
      tick();
      idle();
      chk("lu_fwd", {12'd0, fwd}, 16'h0004);
      chk("lu_cnt", stall_cnt, 16'd1);
      drain();

      // add x3,x1,x2 ; sub x4,x3,x3
      drv(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 2'b00, 1'b0);
      tick();
      drv(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 2'b00, 1'b0);
      chk("raw_nostall", {12'd0, ctl}, 16'h0000);
      tick();
      idle();
      chk("raw_fwd", {12'd0, fwd}, 16'h000A);
      drain();

      // two writers of x8 in MEM and WB
      drv(1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 2'b00, 1'b0);
      tick();
      drv(1'b1, 5'd2, 5'd0, 5'd8, 1'b1, 2'b00, 1'b0);
      tick();
      drv(1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 2'b00, 1'b0);
      chk("x8_nostall", {12'd0, ctl}, 16'h0000);
      tick();
      idle();
      chk("mem_wins", {12'd0, fwd}, 16'h000A);
      drain();

      // WB-only writer of x10 seen on operand b
      drv(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 2'b00, 1'b0);
      tick();
      idle();
      tick();
      drv(1'b1, 5'd0, 5'd10, 5'd11, 1'b1, 2'b00, 1'b0);
      tick();
      idle();
      chk("wb_fwd_b", {12'd0, fwd}, 16'h0001);
      drain();

      // load-use coinciding with a taken branch
      drv(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0);
      tick();
      drv(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 2'b00, 1'b1);
      chk("pc_prio_ctl", {12'd0, ctl}, 16'h0003);
      chk("pc_prio_cnt", stall_cnt, 16'd1);
      tick();
      idle();
      chk("flush_done", {12'd0, ctl}, 16'h0000);
      chk("pc_cnt_after", stall_cnt, 16'd1);
      drain();

      // lw x0 ; add x1,x0,x0
      drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 2'b01, 1'b0);
      tick();
      drv(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 2'b00, 1'b0);
      chk("x0_nostall", {12'd0, ctl}, 16'h0000);
      tick();
      idle();
      chk("x0_fwd_mem", {12'd0, fwd}, 16'h0000);
      tick();
      chk("x0_fwd_wb", {12'd0, fwd}, 16'h0000);
      chk("x0_cnt", stall_cnt, 16'd1);
      drain();

      // reset pulsed while in STALL
      drv(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0);
      tick();
      drv(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 2'b00, 1'b0);
      chk("pre_rst_stall", {12'd0, ctl}, 16'h000D);
      tick();
      chk("pre_rst_cnt", stall_cnt, 16'd2);
      rst = 1'b1;
      drv(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 2'b01, 1'b1);
      chk("mid_rst_ctl", {12'd0, ctl}, 16'h0000);
      chk("mid_rst_fwd", {12'd0, fwd}, 16'h0000);
      chk("mid_rst_cnt", stall_cnt, 16'h0000);
      tick();
      rst = 1'b0;
      idle();
      chk("post_rst_ctl", {12'd0, ctl}, 16'h0000);
      tick();
      chk("post_rst_ctl2", {12'd0, ctl}, 16'h0000);
      drv(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0);
      tick();
      drv(1'b1, 5'd7, 5'd5, 5'd6, 1'b1, 2'b00, 1'b0);
      chk("post_rst_stall", {12'd0, ctl}, 16'h000D);
      tick();
      chk("post_rst_cnt", stall_cnt, 16'd1);
      drain();

      // saturation from a preloaded counter
      @(negedge clk);
      force dut.r_stall_cnt = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.r_stall_cnt;
      chk("preload", stall_cnt, 16'hFFFF);
      drv(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0);
      tick();
      drv(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 2'b00, 1'b0);
      chk("sat_stall", {12'd0, ctl}, 16'h000D);
      tick();
      idle();
      chk("sat_cnt", stall_cnt, 16'hFFFF);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
